// File: rtl/rf_write_arbiter.sv
// Write-port sequencer for the 32x64 register file: round-robin arbitration
// between two valid/ready requesters, plus an init sequencer that zeroes every register.
module rf_write_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_reg,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_reg,
    input  logic [DW-1:0] req1_data,
    input  logic          init_start,
    output logic          init_busy,
    output logic [AW-1:0] rf_wReg,
    output logic [DW-1:0] rf_data,
    output logic          rf_RegWrite
);

    typedef enum logic [0:0] {
        IDLE,
        INIT
    } state_t;

    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          init_busy_q, init_busy_d;
    logic [AW-1:0] rf_wreg_q, rf_wreg_d;
    logic [DW-1:0] rf_data_q, rf_data_d;
    logic          rf_we_q, rf_we_d;

    logic grant0, grant1, accept_en;

    // last_grant_q == 1 means requester 1 won last, so requester 0 wins the next tie.
    always_comb begin
        grant0    = req0_valid && (!req1_valid || last_grant_q);
        grant1    = req1_valid && (!req0_valid || !last_grant_q);
        accept_en = !reset && (state_q == IDLE) && !init_start;
    end

    assign req0_ready = accept_en && grant0;
    assign req1_ready = accept_en && grant1;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        init_busy_d  = init_busy_q;
        rf_wreg_d    = rf_wreg_q;
        rf_data_d    = rf_data_q;
        rf_we_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d     = INIT;
                    cnt_d       = '0;
                    init_busy_d = 1'b1;
                    rf_wreg_d   = '0;
                    rf_data_d   = '0;
                    rf_we_d     = 1'b1;
                end else if (req0_ready) begin
                    rf_wreg_d    = req0_reg;
                    rf_data_d    = req0_data;
                    rf_we_d      = (req0_reg != '0);
                    last_grant_d = 1'b0;
                end else if (req1_ready) begin
                    rf_wreg_d    = req1_reg;
                    rf_data_d    = req1_data;
                    rf_we_d      = (req1_reg != '0);
                    last_grant_d = 1'b1;
                end
            end
            INIT: begin
                // rf_wReg tracks cnt, so the write for cnt+1 is staged while cnt is on the bus.
                if (cnt_q == LAST_REG) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    init_busy_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + AW'(1);
                    rf_wreg_d = cnt_q + AW'(1);
                    rf_data_d = '0;
                    rf_we_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            init_busy_q  <= 1'b0;
            rf_wreg_q    <= '0;
            rf_data_q    <= '0;
            rf_we_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            init_busy_q  <= init_busy_d;
            rf_wreg_q    <= rf_wreg_d;
            rf_data_q    <= rf_data_d;
            rf_we_q      <= rf_we_d;
        end
    end

    assign init_busy   = init_busy_q;
    assign rf_wReg     = rf_wreg_q;
    assign rf_data     = rf_data_q;
    assign rf_RegWrite = rf_we_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a cycle table for handshakes and arbitration, then hand
// sequences for init, init ignored mid-sequence, and reset aborting an init.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, init_start = 1'b0;
    logic [4:0]  req0_reg = '0, req1_reg = '0;
    logic [63:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, init_busy, rf_RegWrite;
    logic [4:0]  rf_wReg;
    logic [63:0] rf_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Register-file model fed from the DUT's write port.
    logic [63:0] rf_model [32] = '{default: '0};

    rf_write_arbiter #(.NREG(32), .AW(5), .DW(64)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .init_start(init_start), .init_busy(init_busy),
        .rf_wReg(rf_wReg), .rf_data(rf_data), .rf_RegWrite(rf_RegWrite)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_RegWrite) rf_model[rf_wReg] <= rf_data;
    end

    typedef struct {
        logic        rst, init, v0;
        logic [4:0]  g0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  g1;
        logic [63:0] d1;
        logic        e_r0, e_r1, e_busy, e_we, chk;
        logic [4:0]  e_wreg;
        logic [63:0] e_data;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(bit rst, bit init, bit v0, int g0, int d0, bit v1, int g1, int d1,
                                bit r0, bit r1, bit busy, bit we, bit chk, int wreg, int data);
        vec_t v;
        v.rst = rst; v.init = init; v.v0 = v0; v.g0 = 5'(g0); v.d0 = 64'(d0);
        v.v1 = v1; v.g1 = 5'(g1); v.d1 = 64'(d1);
        v.e_r0 = r0; v.e_r1 = r1; v.e_busy = busy; v.e_we = we; v.chk = chk;
        v.e_wreg = 5'(wreg); v.e_data = 64'(data);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_port(input string tag, input bit r0, input bit r1, input bit busy,
                              input bit we, input bit chk, input int wreg, input int data);
        check({tag, " req0_ready"}, 64'(req0_ready), 64'(r0));
        check({tag, " req1_ready"}, 64'(req1_ready), 64'(r1));
        check({tag, " init_busy"}, 64'(init_busy), 64'(busy));
        check({tag, " rf_RegWrite"}, 64'(rf_RegWrite), 64'(we));
        if (chk) begin
            check({tag, " rf_wReg"}, 64'(rf_wReg), 64'(wreg));
            check({tag, " rf_data"}, rf_data, 64'(data));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             rst in v0 g0 d0   v1 g1 d1  | r0 r1 bz we ck wreg data
        vecs[0]  = mk(1, 0, 1, 3, 30,  0, 0, 0,    0, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 1, 3, 30,  0, 0, 0,    1, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1, 3, 30);
        vecs[3]  = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 1, 3, 30);
        vecs[4]  = mk(1, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 1, 1, 10,  1, 5, 50,   1, 0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 1, 2, 20,  1, 5, 50,   0, 1, 0, 1, 1, 1, 10);
        vecs[7]  = mk(0, 0, 1, 2, 20,  1, 6, 60,   1, 0, 0, 1, 1, 5, 50);
        vecs[8]  = mk(0, 0, 1, 3, 30,  1, 6, 60,   0, 1, 0, 1, 1, 2, 20);
        vecs[9]  = mk(0, 0, 1, 3, 30,  1, 7, 70,   1, 0, 0, 1, 1, 6, 60);
        vecs[10] = mk(0, 0, 1, 4, 40,  1, 7, 70,   0, 1, 0, 1, 1, 3, 30);
        vecs[11] = mk(0, 0, 1, 4, 40,  1, 8, 80,   1, 0, 0, 1, 1, 7, 70);
        vecs[12] = mk(0, 0, 0, 0, 0,   1, 8, 80,   0, 1, 0, 1, 1, 4, 40);
        vecs[13] = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1, 8, 80);
        vecs[14] = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 1, 8, 80);
        vecs[15] = mk(0, 0, 1, 0, 99,  0, 0, 0,    1, 0, 0, 0, 1, 8, 80);
        vecs[16] = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 1, 0, 99);
        vecs[17] = mk(0, 0, 1, 10, 100, 1, 11, 110, 0, 1, 0, 0, 1, 0, 99);
        vecs[18] = mk(0, 0, 1, 10, 100, 0, 0, 0,   1, 0, 0, 1, 1, 11, 110);
        vecs[19] = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1, 10, 100);
        vecs[20] = mk(1, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 1, 0, 0);
        vecs[21] = mk(0, 0, 1, 9, 1,   1, 9, 2,    1, 0, 0, 0, 1, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0,   1, 9, 2,    0, 1, 0, 1, 1, 9, 1);
        vecs[23] = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 1, 9, 2);
        vecs[24] = mk(0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 1, 9, 2);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; init_start = vecs[i].init;
            req0_valid = vecs[i].v0; req0_reg = vecs[i].g0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_reg = vecs[i].g1; req1_data = vecs[i].d1;
            #1;
            check_port($sformatf("vec%0d", i), vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_busy,
                       vecs[i].e_we, vecs[i].chk, int'(vecs[i].e_wreg), int'(vecs[i].e_data));
        end

        for (int k = 1; k <= 8; k++) check($sformatf("rf[%0d] after table", k), rf_model[k], 64'(k * 10));
        check("rf[0] after reg0 write", rf_model[0], 64'd0);
        check("rf[9] conflict", rf_model[9], 64'd2);
        check("rf[11] after tie", rf_model[11], 64'd110);

        // Init with req1 waiting: blocked on the start cycle and for all 32 init cycles.
        @(negedge clk);
        init_start = 1'b1; req0_valid = 1'b0;
        req1_valid = 1'b1; req1_reg = 5'd12; req1_data = 64'd120;
        #1;
        check_port("init start", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            init_start = (k == 5);
            #1;
            check_port($sformatf("init cyc%0d", k), 0, 0, 1, 1, 1, k, 0);
        end
        @(negedge clk);
        init_start = 1'b0;
        #1;
        check_port("init done", 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check_port("post-init write", 0, 0, 0, 1, 1, 12, 120);
        @(negedge clk);
        for (int k = 0; k < 32; k++)
            check($sformatf("rf[%0d] after init", k), rf_model[k], (k == 12) ? 64'd120 : 64'd0);

        // Fill 1..31, then reset during the init cycle that writes reg 9.
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_reg = 5'(k); req0_data = 64'(1000 + k);
            #1;
            check($sformatf("fill%0d req0_ready", k), 64'(req0_ready), 64'd1);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        init_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            init_start = 1'b0;
            #1;
            check($sformatf("abort init wReg%0d", k), 64'(rf_wReg), 64'(k));
        end
        req0_valid = 1'b1; req0_reg = 5'd13; req0_data = 64'd7;
        req1_valid = 1'b1; req1_reg = 5'd14; req1_data = 64'd8;
        #1 reset = 1'b1;
        #1;
        check_port("mid-init reset", 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_port("after abort", 1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 32; k++)
            check($sformatf("rf[%0d] after abort", k), rf_model[k], (k < 9) ? 64'd0 : 64'(1000 + k));
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check_port("req0 after abort", 0, 1, 0, 1, 1, 13, 7);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check_port("req1 after abort", 0, 0, 0, 1, 1, 14, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sequences the single write port of the 32x64 register file (`rf`): wReg, data, RegWrite.
- Two requesters, e.g. ALU writeback and load writeback, share that port through a valid/ready handshake with round-robin arbitration.
- Also contains an init sequencer that zeroes every register, one per cycle, on command.
- All rf-side outputs are registered; they connect directly to rf's wReg/data/RegWrite.

Parameters:
- NREG, 32, number of registers in rf.
- AW, 5, register address width; must satisfy 2**AW == NREG.
- DW, 64, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_ready  output  1  requester 0 accepted this cycle (combinational).
- req0_reg  input  AW  requester 0 destination register.
- req0_data  input  DW  requester 0 write data.
- req1_valid  input  1  requester 1 has a write pending.
- req1_ready  output  1  requester 1 accepted this cycle (combinational).
- req1_reg  input  AW  requester 1 destination register.
- req1_data  input  DW  requester 1 write data.
- init_start  input  1  one-cycle pulse to zero all registers.
- init_busy  output  1  init sequence in progress.
- rf_wReg  output  AW  to rf wReg.
- rf_data  output  DW  to rf data.
- rf_RegWrite  output  1  to rf RegWrite.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, cnt=0, last_grant=1 (requester 0 wins the first tie).
  - rf_wReg=0, rf_data=0, rf_RegWrite=0, init_busy=0.
  - req0_ready=req1_ready=0 while reset is high.
- FSM states: IDLE, INIT.
- IDLE, handshake:
  - reqX_ready=1 only when state==IDLE, init_start==0 and requester X is granted.
  - Transfer occurs when valid && ready at a posedge. At most one transfer per cycle.
  - Grant when only one valid: that requester.
  - Grant when both valid: the requester that is not last_grant. last_grant updates to the granted requester on transfer only.
  - Neither valid: no grant, last_grant holds.
  - A requester must hold reg/data stable while valid && !ready. The arbiter does not check this.
- Write latency: a transfer at posedge N drives rf_wReg/rf_data = accepted values and rf_RegWrite=1 during cycle N+1 (registered, one cycle). The rf captures the write at posedge N+1.
- Register 0: a request with reg==0 is accepted normally (ready, last_grant updates), but rf_RegWrite stays 0 for that slot, so the write is dropped. rf_wReg/rf_data still update.
- No transfer in a cycle: rf_RegWrite=0 the next cycle. rf_wReg/rf_data hold their previous values.
- IDLE -> INIT: init_start==1 in IDLE at posedge N.
  - init_start has priority over requests that cycle; no transfer occurs.
  - cnt=0; init_busy=1 from cycle N+1.
- INIT:
  - Each cycle drives rf_wReg=cnt, rf_data=0, rf_RegWrite=1 (register 0 included), then cnt increments.
  - Cycles N+1..N+NREG write regs 0..NREG-1.
  - At the posedge ending the cnt==NREG-1 cycle: state->IDLE, init_busy=0, rf_RegWrite=0 next cycle, cnt wraps to 0.
  - During INIT: both readys are 0, init_start is ignored, and requests wait without being dropped.
- Same-register conflicts: two requests to the same register are written in grant order; the later write wins. No merging.
- Reset mid-INIT or mid-write: the async reset aborts immediately and returns everything to the reset values. A pending rf write is lost. Registers already zeroed stay zeroed.

Test Plan:
- Reset, then req0 alone (reg=3, data=30) held one cycle -> req0_ready=1 that cycle; next cycle rf_wReg=3, rf_data=30, rf_RegWrite=1; the cycle after, RegWrite=0.
- Both valid continuously, req0 writes 1..4 (data 10,20,30,40), req1 writes 5..8 (data 50..80) -> grants alternate 0,1,0,1,...; rf writes regs 1,5,2,6,3,7,4,8 back-to-back with RegWrite=1 every cycle; rf reads back k*10.
- req0_valid with reg=0, data=99 -> req0_ready=1, rf_RegWrite stays 0; rf reg[0] reads 0.
- Fill regs via requests, then pulse init_start with req1_valid=1 the same cycle -> req1_ready=0; init_busy high exactly 32 cycles; rf_wReg steps 0..31 with data 0; req1 accepted in the first IDLE cycle afterwards; all other regs read 0.
- Both requesters target reg 9, req0 data=1, req1 data=2, both valid the same cycle after reset -> req0 granted first, then req1; reg[9]=2.
- Assert reset at INIT cycle 10 -> outputs drop to 0 immediately, init_busy=0; after release, regs 0..8 read 0 and the rest keep their old values; a new request proceeds normally with req0 winning the first tie.
